nios2_jtag_debug_ocimem_arbiter: RTL and testbench
==================================================

# nios2_jtag_debug_ocimem_arbiter

Arbiter/sequencer that shares the Nios II on-chip debug memory (OCI RAM, single-port, 1-cycle read latency) between the JTAG debug path and the CPU's debug slave port. It sits in the system-clock domain after the JTAG-to-sysclk command handoff. It queues JTAG debug commands (address set, read, write) in a small FIFO and grants RAM cycles against CPU Avalon-MM accesses. JTAG read results are returned on `mon_dreg` with ready/error status.

## Interface
Parameters:
- `AW`, 8: OCI RAM word-address width.
- `FIFO_DEPTH`, 4: JTAG command FIFO depth; power of 2, ≥2.
- `STARVE_LIMIT`, 4: consecutive CPU grants tolerated while JTAG is pending. Used only with the macro.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `jcmd_valid` in 1: one-cycle command strobe (a take_action pulse); cannot be back-pressured.
- `jcmd_op` in 2: command opcode; 0 SET_ADDR, 1 READ, 2 WRITE, 3 reserved.
- `jdo` in 38: command payload; `jdo[AW-1:0]` address (SET_ADDR), `jdo[34:3]` write data.
- `cpu_address` in AW: CPU debug-slave word address.
- `cpu_read` / `cpu_write` in 1: Avalon requests; held until accepted.
- `cpu_writedata` in 32: CPU write data.
- `cpu_waitrequest` out 1: request not accepted this cycle.
- `cpu_readdata` out 32, `cpu_readdatavalid` out 1: read response.
- `ram_addr` out AW, `ram_wren` out 1, `ram_wdata` out 32, `ram_rdata` in 32: OCI RAM port.
- `mon_dreg` out 32: last JTAG read data.
- `monitor_ready` out 1: JTAG queue drained and last command complete.
- `monitor_error` out 1: sticky; a command was dropped on overflow or was op 3.

## Operation
- FSM states: IDLE, CPU_ACC, JTAG_ACC, CPU_RESP, JTAG_RESP.
- IDLE arbitration:
  - A CPU request has priority over a non-empty FIFO.
  - If neither is present, stay in IDLE.
- SET_ADDR at FIFO head is executed in IDLE:
  - Load the JTAG address pointer `jaddr`, pop, stay in IDLE. No RAM cycle.
  - It does not count as a grant and does not block a CPU request in the same cycle, since the CPU wins.
- CPU_ACC:
  - Drive `ram_addr=cpu_address`, `ram_wren=cpu_write`, `ram_wdata=cpu_writedata`; `cpu_waitrequest=0`.
  - Next state is CPU_RESP for a read, IDLE for a write.
- JTAG_ACC:
  - Drive `ram_addr=jaddr`; for WRITE, `ram_wren=1`, `ram_wdata=jdo[34:3]` (stored payload).
  - Pop the FIFO and set `jaddr<=jaddr+1`, wrapping modulo 2^AW.
  - Next state is JTAG_RESP for READ, IDLE for WRITE.
- CPU_RESP: `cpu_readdatavalid=1`, `cpu_readdata=ram_rdata`; then IDLE.
- JTAG_RESP: `mon_dreg<=ram_rdata`; then IDLE.
- Op 3: popped in IDLE, sets `monitor_error`, no other effect.
- `cpu_waitrequest` = 1 whenever the state is not CPU_ACC, including when idle.
- `monitor_ready`:
  - Goes to 1 the cycle after the FIFO is empty and the FSM is IDLE with no JTAG op in flight.
  - Goes to 0 the cycle after any push.
- FIFO:
  - Push when `jcmd_valid`. If full and no pop in the same cycle, drop the command and set `monitor_error`.
  - A push to a full FIFO with a simultaneous pop is accepted.
- `monitor_error` clears only on reset.

## Timing
- Reset values: state IDLE, FIFO empty, `jaddr=0`, `cpu_waitrequest=1`, `cpu_readdatavalid=0`, `cpu_readdata=0`, `ram_wren=0`, `ram_addr=0`, `ram_wdata=0`, `mon_dreg=0`, `monitor_ready=1`, `monitor_error=0`.
- Reset mid-operation abandons any access. No response pulse is issued after reset.
- CPU request seen in IDLE at cycle N:
  - Accepted (waitrequest low) at N+1.
  - Read data valid at N+2.
  - Minimum 2 cycles per write, 3 per read.
- JTAG command pushed at cycle N:
  - Earliest grant is N+2 (registered FIFO output).
  - `mon_dreg` is updated at the end of N+3 for a READ.
- Back-to-back CPU requests starve JTAG indefinitely unless the macro is defined.

## Configuration
- `NIOS2_OCIMEM_ARB_STARVE_GUARD_EN`:
  - Defined: a counter increments on each CPU grant while the FIFO holds a READ/WRITE head, and resets on a JTAG grant. When it reaches `STARVE_LIMIT`, the next IDLE arbitration grants JTAG even if a CPU request is present.
  - Not defined: strict CPU priority; no counter logic.

## Structure
- Shared package `nios2_ocimem_arb_pkg`: opcode constants (`OP_SET_ADDR`, `OP_READ`, `OP_WRITE`, `OP_RSVD`) and the FSM state enum.
- Sub-module `nios2_ocimem_cmd_fifo`: synchronous FIFO of {op[1:0], jdo[37:0]}.
  - Ports: push, pop, full, empty, head; registered head.
  - Width 40, depth `FIFO_DEPTH`.

## Test plan
- SET_ADDR 0x10, WRITE 0xDEADBEEF, SET_ADDR 0x10, READ → RAM[0x10]=0xDEADBEEF, `mon_dreg`=0xDEADBEEF, `jaddr`=0x11, `monitor_ready`=1 at end.
- `jaddr`=0xFF, two WRITEs 0xA, 0xB → RAM[0xFF]=0xA, RAM[0x00]=0xB (wrap).
- CPU read of 0x20 (holding 0x12345678) from IDLE at cycle N → waitrequest low at N+1, readdatavalid=1 with 0x12345678 at N+2.
- CPU read and JTAG WRITE pending in the same cycle → CPU served first, JTAG write in the next IDLE window; no readdata corruption.
- 6 strobes with FIFO_DEPTH=4 and the CPU holding the RAM → 4 queued, `monitor_error`=1, the 4 executed in order.
- Macro on, STARVE_LIMIT=4, continuous CPU reads with a JTAG READ queued → JTAG granted after exactly 4 CPU grants. Macro off → JTAG is never granted until the CPU goes idle.

Source files
------------

// File: rtl/nios2_ocimem_arb_pkg.sv
// Shared definitions for the Nios II OCI RAM arbiter.
//   - JTAG command opcodes carried alongside the 38-bit jdo payload
//   - command FIFO entry width ({op[1:0], jdo[37:0]})
//   - arbiter FSM state encoding
package nios2_ocimem_arb_pkg;

    localparam logic [1:0] OP_SET_ADDR = 2'd0;
    localparam logic [1:0] OP_READ     = 2'd1;
    localparam logic [1:0] OP_WRITE    = 2'd2;
    localparam logic [1:0] OP_RSVD     = 2'd3;

    localparam int CMD_W = 40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU_ACC,
        S_JTAG_ACC,
        S_CPU_RESP,
        S_JTAG_RESP
    } arb_state_t;

    // Opcodes that need an OCI RAM cycle (the others are handled in IDLE).
    function automatic logic op_uses_ram(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/nios2_ocimem_cmd_fifo.sv
// Synchronous command FIFO for queued JTAG debug commands.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   push, din   - write strobe and entry; ignored when full unless popping
//   pop         - remove head entry; ignored when empty
//   full, empty - occupancy flags
//   head        - current head entry, read straight from the storage flops
module nios2_ocimem_cmd_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios2_jtag_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM (1-cycle read latency) between queued
// JTAG debug commands and the CPU debug slave (Avalon-MM).
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   jcmd_valid/op, jdo    - JTAG command strobe, opcode, payload (no backpressure)
//   cpu_*                 - Avalon-MM debug slave (waitrequest, readdatavalid)
//   ram_*                 - OCI RAM port
//   mon_dreg              - data of the last JTAG READ
//   monitor_ready         - JTAG queue drained and last command finished
//   monitor_error         - sticky: command dropped on overflow, or opcode 3
// Build option:
//   NIOS2_OCIMEM_ARB_STARVE_GUARD_EN - after STARVE_LIMIT CPU grants with a
//   JTAG RAM command waiting, the next arbitration goes to JTAG. Undefined:
//   strict CPU priority.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | arbitrate; execute SET_ADDR / reserved ops at FIFO head
// S_CPU_ACC   | CPU owns the RAM port, waitrequest low
// S_JTAG_ACC  | JTAG read/write at jaddr, head popped, jaddr advances
// S_CPU_RESP  | RAM read data returned to the CPU (readdatavalid)
// S_JTAG_RESP | RAM read data captured into mon_dreg
module nios2_jtag_debug_ocimem_arbiter
    import nios2_ocimem_arb_pkg::*;
#(
    parameter int AW           = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          jcmd_valid,
    input  logic [1:0]    jcmd_op,
    input  logic [37:0]   jdo,
    input  logic [AW-1:0] cpu_address,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [31:0]   cpu_writedata,
    output logic          cpu_waitrequest,
    output logic [31:0]   cpu_readdata,
    output logic          cpu_readdatavalid,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wren,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    output logic [31:0]   mon_dreg,
    output logic          monitor_ready,
    output logic          monitor_error
);

    arb_state_t       state;
    logic [AW-1:0]    jaddr;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CMD_W-1:0] fifo_head;
    logic [1:0]       head_op;
    logic             head_local;
    logic             head_ram;
    logic             in_idle;
    logic             cpu_req;
    logic             starve_force;
    logic             grant_cpu;
    logic             grant_jtag;
    logic             jcmd_drop;
    logic             unused_head_bits;

    nios2_ocimem_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (jcmd_valid),
        .din   ({jcmd_op, jdo}),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign head_op    = fifo_head[39:38];
    assign in_idle    = (state == S_IDLE);
    assign cpu_req    = cpu_read || cpu_write;
    assign head_local = !fifo_empty && !op_uses_ram(head_op);
    assign head_ram   = !fifo_empty && op_uses_ram(head_op);

    // SET_ADDR / reserved leave in IDLE without a RAM cycle, even while the
    // CPU is being granted; READ/WRITE leave at the end of their RAM cycle.
    assign fifo_pop   = (in_idle && head_local) || (state == S_JTAG_ACC);
    assign jcmd_drop  = jcmd_valid && fifo_full && !fifo_pop;

    assign grant_cpu  = in_idle && cpu_req && !starve_force;
    assign grant_jtag = in_idle && head_ram && !grant_cpu;

    // Payload bits above the write data field carry nothing for this block.
    assign unused_head_bits = ^fifo_head[37:35];

`ifdef NIOS2_OCIMEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;

    assign starve_force = head_ram && (starve_cnt >= SW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_jtag) begin
            starve_cnt <= '0;
        end else if (grant_cpu && head_ram) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // Strict CPU priority: the starvation limit has no effect in this build.
    assign starve_force = (STARVE_LIMIT < 0);
`endif

    // Read data goes straight from the RAM in the response cycle so that a
    // read completes two cycles after the request is seen.
    assign cpu_readdata = cpu_readdatavalid ? ram_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            jaddr             <= '0;
            cpu_waitrequest   <= 1'b1;
            cpu_readdatavalid <= 1'b0;
            ram_addr          <= '0;
            ram_wren          <= 1'b0;
            ram_wdata         <= '0;
            mon_dreg          <= '0;
            monitor_ready     <= 1'b1;
            monitor_error     <= 1'b0;
        end else begin
            cpu_waitrequest   <= 1'b1;
            cpu_readdatavalid <= 1'b0;
            ram_wren          <= 1'b0;

            if (jcmd_drop || (in_idle && head_local && head_op == OP_RSVD)) begin
                monitor_error <= 1'b1;
            end

            if (jcmd_valid) begin
                monitor_ready <= 1'b0;
            end else if (in_idle && fifo_empty) begin
                monitor_ready <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (head_local && head_op == OP_SET_ADDR) begin
                        jaddr <= fifo_head[AW-1:0];
                    end
                    if (grant_cpu) begin
                        state           <= S_CPU_ACC;
                        cpu_waitrequest <= 1'b0;
                        ram_addr        <= cpu_address;
                        ram_wren        <= cpu_write;
                        ram_wdata       <= cpu_writedata;
                    end else if (grant_jtag) begin
                        state    <= S_JTAG_ACC;
                        ram_addr <= jaddr;
                        if (head_op == OP_WRITE) begin
                            ram_wren  <= 1'b1;
                            ram_wdata <= fifo_head[34:3];
                        end
                    end
                end
                // ram_wren still holds the access type registered on entry.
                S_CPU_ACC: begin
                    if (ram_wren) begin
                        state <= S_IDLE;
                    end else begin
                        state             <= S_CPU_RESP;
                        cpu_readdatavalid <= 1'b1;
                    end
                end
                S_JTAG_ACC: begin
                    jaddr <= jaddr + 1'b1;
                    state <= ram_wren ? S_IDLE : S_JTAG_RESP;
                end
                S_CPU_RESP: begin
                    state <= S_IDLE;
                end
                S_JTAG_RESP: begin
                    mon_dreg <= ram_rdata;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_jtag_debug_ocimem_arbiter.sv
// Directed self-checking bench for nios2_jtag_debug_ocimem_arbiter.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
// Honours NIOS2_OCIMEM_ARB_STARVE_GUARD_EN in the starvation scenario.
module tb_nios2_jtag_debug_ocimem_arbiter;
    import nios2_ocimem_arb_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          jcmd_valid;
    logic [1:0]    jcmd_op;
    logic [37:0]   jdo;
    logic [AW-1:0] cpu_address;
    logic          cpu_read;
    logic          cpu_write;
    logic [31:0]   cpu_writedata;
    logic          cpu_waitrequest;
    logic [31:0]   cpu_readdata;
    logic          cpu_readdatavalid;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [31:0]   mon_dreg;
    logic          monitor_ready;
    logic          monitor_error;

    logic          ram_init;
    logic [31:0]   ram [256];

    int n_tests = 0;
    int n_fail  = 0;

    nios2_jtag_debug_ocimem_arbiter #(
        .AW           (AW),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .jcmd_valid        (jcmd_valid),
        .jcmd_op           (jcmd_op),
        .jdo               (jdo),
        .cpu_address       (cpu_address),
        .cpu_read          (cpu_read),
        .cpu_write         (cpu_write),
        .cpu_writedata     (cpu_writedata),
        .cpu_waitrequest   (cpu_waitrequest),
        .cpu_readdata      (cpu_readdata),
        .cpu_readdatavalid (cpu_readdatavalid),
        .ram_addr          (ram_addr),
        .ram_wren          (ram_wren),
        .ram_wdata         (ram_wdata),
        .ram_rdata         (ram_rdata),
        .mon_dreg          (mon_dreg),
        .monitor_ready     (monitor_ready),
        .monitor_error     (monitor_error)
    );

    always #5 clk = ~clk;

    // OCI RAM model: single port, registered read data.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
        end else if (ram_wren) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] wr_payload(input logic [31:0] v);
        return {3'b000, v, 3'b000};
    endfunction

    task automatic jcmd(input logic [1:0] op, input logic [37:0] d);
        jcmd_valid = 1'b1;
        jcmd_op    = op;
        jdo        = d;
        tick();
        jcmd_valid = 1'b0;
        jcmd_op    = 2'd0;
        jdo        = '0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 60 && !monitor_ready; i++) tick();
        check(tag, monitor_ready, 1'b1);
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [31:0] d);
        cpu_write     = 1'b1;
        cpu_address   = a;
        cpu_writedata = d;
        tick();
        for (int i = 0; i < 20 && cpu_waitrequest; i++) tick();
        check("cpu_wr_accept", cpu_waitrequest, 1'b0);
        tick();
        cpu_write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int grants;
        bit jtag_seen;

        reset = 1'b1; ram_init = 1'b1;
        jcmd_valid = 1'b0; jcmd_op = 2'd0; jdo = '0;
        cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0;
        repeat (3) tick();
        ram_init = 1'b0;

        check("rst_waitreq", cpu_waitrequest, 1'b1);
        check("rst_rdvalid", cpu_readdatavalid, 1'b0);
        check("rst_rdata", cpu_readdata, 32'h0);
        check("rst_wren", ram_wren, 1'b0);
        check("rst_addr", ram_addr, 32'h0);
        check("rst_wdata", ram_wdata, 32'h0);
        check("rst_mon_dreg", mon_dreg, 32'h0);
        check("rst_ready", monitor_ready, 1'b1);
        check("rst_error", monitor_error, 1'b0);
        reset = 1'b0;
        tick();

        // SET_ADDR/WRITE/SET_ADDR/READ round trip
        jcmd(OP_SET_ADDR, 38'h10);
        check("t1_ready_drop", monitor_ready, 1'b0);
        jcmd(OP_WRITE, wr_payload(32'hDEADBEEF));
        jcmd(OP_SET_ADDR, 38'h10);
        jcmd(OP_READ, 38'h0);
        wait_ready("t1_ready");
        check("t1_ram10", ram[8'h10], 32'hDEADBEEF);
        check("t1_mon_dreg", mon_dreg, 32'hDEADBEEF);
        // jaddr must have advanced to 0x11
        jcmd(OP_WRITE, wr_payload(32'h55));
        wait_ready("t1_ready2");
        check("t1_jaddr_inc", ram[8'h11], 32'h55);

        // address wrap
        jcmd(OP_SET_ADDR, 38'hFF);
        jcmd(OP_WRITE, wr_payload(32'hA));
        jcmd(OP_WRITE, wr_payload(32'hB));
        wait_ready("t2_ready");
        check("t2_ramFF", ram[8'hFF], 32'hA);
        check("t2_ram00", ram[8'h00], 32'hB);

        // JTAG READ latency: grant at N+2, mon_dreg new at N+4
        jcmd(OP_SET_ADDR, 38'hFF);
        wait_ready("t2_ready2");
        jcmd(OP_READ, 38'h0);
        tick();
        check("t2_jgrant_addr", ram_addr, 32'hFF);
        check("t2_jgrant_wren", ram_wren, 1'b0);
        check("t2_jgrant_wait", cpu_waitrequest, 1'b1);
        tick();
        check("t2_mon_old", mon_dreg, 32'hDEADBEEF);
        tick();
        check("t2_mon_new", mon_dreg, 32'hA);
        wait_ready("t2_ready3");

        // CPU read timing
        cpu_wr(8'h20, 32'h12345678);
        cpu_read = 1'b1; cpu_address = 8'h20;
        check("t3_wait_n", cpu_waitrequest, 1'b1);
        tick();
        check("t3_wait_n1", cpu_waitrequest, 1'b0);
        check("t3_rdv_n1", cpu_readdatavalid, 1'b0);
        tick();
        cpu_read = 1'b0;
        check("t3_rdv_n2", cpu_readdatavalid, 1'b1);
        check("t3_rdata_n2", cpu_readdata, 32'h12345678);
        check("t3_wait_n2", cpu_waitrequest, 1'b1);
        tick();
        check("t3_rdv_n3", cpu_readdatavalid, 1'b0);

        // CPU read and JTAG WRITE arrive together: CPU first
        jcmd(OP_SET_ADDR, 38'h30);
        wait_ready("t4_ready0");
        cpu_read = 1'b1; cpu_address = 8'h20;
        jcmd(OP_WRITE, wr_payload(32'h77));
        check("t4_cpu_first", cpu_waitrequest, 1'b0);
        check("t4_cpu_addr", ram_addr, 32'h20);
        check("t4_cpu_nowr", ram_wren, 1'b0);
        tick();
        cpu_read = 1'b0;
        check("t4_rdv", cpu_readdatavalid, 1'b1);
        check("t4_rdata", cpu_readdata, 32'h12345678);
        wait_ready("t4_ready");
        check("t4_ram30", ram[8'h30], 32'h77);
        check("t4_no_error", monitor_error, 1'b0);

        // overflow while the CPU holds the RAM
        jcmd(OP_SET_ADDR, 38'h40);
        wait_ready("t5_ready0");
        cpu_read = 1'b1; cpu_address = 8'h20;
        tick();
        for (int i = 1; i <= 6; i++) jcmd(OP_WRITE, wr_payload(32'(i)));
        check("t5_error", monitor_error, 1'b1);
        cpu_read = 1'b0;
        wait_ready("t5_ready");
        check("t5_ram40", ram[8'h40], 32'h1);
        check("t5_ram41", ram[8'h41], 32'h2);
        check("t5_ram42", ram[8'h42], 32'h3);
        check("t5_ram43", ram[8'h43], 32'h4);
        check("t5_ram44", ram[8'h44], 32'h0);
        check("t5_error_sticky", monitor_error, 1'b1);

        // reset clears error; reserved opcode sets it; jaddr back to 0
        do_reset();
        check("t6_rst_error", monitor_error, 1'b0);
        check("t6_rst_mon", mon_dreg, 32'h0);
        check("t6_rst_ready", monitor_ready, 1'b1);
        jcmd(OP_RSVD, wr_payload(32'h99));
        wait_ready("t6_ready");
        check("t6_rsvd_error", monitor_error, 1'b1);
        jcmd(OP_READ, 38'h0);
        wait_ready("t6_ready2");
        check("t6_jaddr_rst", mon_dreg, 32'hB);

        // starvation under continuous CPU reads
        cpu_wr(8'h50, 32'hCAFEF00D);
        jcmd(OP_SET_ADDR, 38'h50);
        wait_ready("t7_ready0");
        cpu_read = 1'b1; cpu_address = 8'h20;
        tick();
        jcmd(OP_READ, 38'h0);
        grants = 0;
        jtag_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ram_addr == 8'h50) begin
                jtag_seen = 1'b1;
                break;
            end
            if (!cpu_waitrequest) grants++;
            tick();
        end
`ifdef NIOS2_OCIMEM_ARB_STARVE_GUARD_EN
        check("t7_jtag_granted", jtag_seen, 1'b1);
        check("t7_cpu_grants", grants, 4);
`else
        check("t7_jtag_starved", jtag_seen, 1'b0);
        check("t7_cpu_busy", grants >= 10, 1'b1);
`endif
        cpu_read = 1'b0;
        wait_ready("t7_ready");
        check("t7_mon_dreg", mon_dreg, 32'hCAFEF00D);

        // reset in the middle of a CPU read: no response afterwards
        cpu_read = 1'b1; cpu_address = 8'h20;
        tick();
        check("t8_accept", cpu_waitrequest, 1'b0);
        reset = 1'b1; cpu_read = 1'b0;
        tick();
        check("t8_rst_rdv", cpu_readdatavalid, 1'b0);
        check("t8_rst_wait", cpu_waitrequest, 1'b1);
        reset = 1'b0;
        tick();
        check("t8_post_rdv", cpu_readdatavalid, 1'b0);
        check("t8_post_ready", monitor_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
